// File: rtl/sprite_pkg.sv
// Shared constants, types and payloads for the sprite fetch pipeline.
// Optional horizontal flip is enabled by defining SPRITE_HFLIP_EN.
package sprite_pkg;

   localparam int unsigned SPR_W   = 32;
   localparam int unsigned SPR_H   = 64;
   localparam int unsigned FRAMES  = 8;
   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned COLOR_W = 12;
   localparam int unsigned COORD_W = 10;
   localparam int unsigned FRAME_W = 3;

   localparam logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F;

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      ACTIVE     = 1'b1
   } state_t;

   // Sprite placement captured once per frame
   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [FRAME_W-1:0] frame;
   } spr_pos_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational hit test and sprite ROM address generation.
// With SPRITE_HFLIP_EN defined, i_flip mirrors the column index.
module sprite_addr_gen
   import sprite_pkg::*;
(
   input  logic [COORD_W-1:0] i_pix_x,
   input  logic [COORD_W-1:0] i_pix_y,
   input  spr_pos_t           i_pos,
`ifdef SPRITE_HFLIP_EN
   input  logic               i_flip,
`endif
   output logic               o_in_box_c,
   output logic [ADDR_W-1:0]  o_addr_c
);

   localparam int unsigned COL_W = $clog2(SPR_W);
   localparam int unsigned ROW_W = $clog2(SPR_H);
   localparam int unsigned D_W   = COORD_W + 1;

   logic signed [D_W-1:0] w_dx;
   logic signed [D_W-1:0] w_dy;
   logic [COL_W-1:0]      w_col;

   // Signed offsets from the sprite origin; no wrap past column/row 1023
   assign w_dx = $signed({1'b0, i_pix_x}) - $signed({1'b0, i_pos.x});
   assign w_dy = $signed({1'b0, i_pix_y}) - $signed({1'b0, i_pos.y});

   assign o_in_box_c = !w_dx[D_W-1] && (32'(w_dx[COORD_W-1:0]) < SPR_W) &&
                       !w_dy[D_W-1] && (32'(w_dy[COORD_W-1:0]) < SPR_H);

`ifdef SPRITE_HFLIP_EN
   assign w_col = i_flip ? (COL_W'(SPR_W - 1) - w_dx[COL_W-1:0]) : w_dx[COL_W-1:0];
`else
   assign w_col = w_dx[COL_W-1:0];
`endif

   // Frame base + row base + column, truncated to the ROM address width
   assign o_addr_c = ADDR_W'(32'(i_pos.frame) * SPR_W * SPR_H +
                             32'(w_dy[ROW_W-1:0]) * SPR_W + 32'(w_col));

endmodule

// File: rtl/sprite_fetch.sv
// Three-stage sprite fetch: address/enable, ROM read, colour-key output.
// Defining SPRITE_HFLIP_EN adds the i_spr_flip port (mirrored columns).
module sprite_fetch
   import sprite_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_pix_valid,
   input  logic [COORD_W-1:0] i_pix_x,
   input  logic [COORD_W-1:0] i_pix_y,
   input  logic               i_vsync,
   input  logic [COORD_W-1:0] i_spr_x,
   input  logic [COORD_W-1:0] i_spr_y,
   input  logic [FRAME_W-1:0] i_spr_frame,
`ifdef SPRITE_HFLIP_EN
   input  logic               i_spr_flip,
`endif
   output logic               o_rom_en,
   output logic [ADDR_W-1:0]  o_rom_addr,
   input  logic [COLOR_W-1:0] i_rom_data,
   output logic               o_px_valid,
   output logic               o_px_hit,
   output logic [COLOR_W-1:0] o_px_color
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_vsync;
   spr_pos_t          r_pos;
   logic              w_vs_rise;
   logic              w_in_box;
   logic [ADDR_W-1:0] w_addr;
   logic              w_rd_en;
   logic              r_v1;
   logic              r_v2;
   logic              r_h2;
   logic              w_opaque;
`ifdef SPRITE_HFLIP_EN
   logic              r_flip;
`endif

   assign w_vs_rise = i_vsync && !r_vsync;

   sprite_addr_gen u_addr_gen (
      .i_pix_x    (i_pix_x),
      .i_pix_y    (i_pix_y),
      .i_pos      (r_pos),
`ifdef SPRITE_HFLIP_EN
      .i_flip     (r_flip),
`endif
      .o_in_box_c (w_in_box),
      .o_addr_c   (w_addr)
   );

   // Capture sprite placement on vsync rise; pixel in that cycle sees the old one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync <= 1'b0;
         r_pos   <= '0;
`ifdef SPRITE_HFLIP_EN
         r_flip  <= 1'b0;
`endif
      end else begin
         r_vsync <= i_vsync;
         if (w_vs_rise) begin
            r_pos <= '{x: i_spr_x, y: i_spr_y, frame: i_spr_frame};
`ifdef SPRITE_HFLIP_EN
            r_flip <= i_spr_flip;
`endif
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= WAIT_FRAME;
      else        r_state <= w_state_nxt;
   end

   // Next state and ROM read request
   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      case (r_state)
         WAIT_FRAME: if (w_vs_rise) w_state_nxt = ACTIVE;
         ACTIVE:     w_rd_en = i_pix_valid && w_in_box;
         default:    w_state_nxt = WAIT_FRAME;
      endcase
   end

   assign w_opaque = r_h2 && (i_rom_data != TRANSPARENT);

   // Pipeline: stage 1 issues the ROM read, stage 2 waits on ROM, stage 3 keys colour
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1       <= 1'b0;
         o_rom_en   <= 1'b0;
         o_rom_addr <= '0;
         r_v2       <= 1'b0;
         r_h2       <= 1'b0;
         o_px_valid <= 1'b0;
         o_px_hit   <= 1'b0;
         o_px_color <= '0;
      end else begin
         r_v1     <= i_pix_valid;
         o_rom_en <= w_rd_en;
         if (w_rd_en) o_rom_addr <= w_addr;
         r_v2       <= r_v1;
         r_h2       <= o_rom_en;
         o_px_valid <= r_v2;
         o_px_hit   <= w_opaque;
         o_px_color <= w_opaque ? i_rom_data : '0;
      end
   end

endmodule

// File: tb/tb_sprite_fetch.sv
// Table-driven bench for sprite_fetch with a 3-deep output scoreboard and ROM model.
module tb_sprite_fetch;

   typedef struct {
      logic        pv;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        vs;
      logic [9:0]  sx;
      logic [9:0]  sy;
      logic [2:0]  fr;
      logic        en;
      logic [13:0] addr;
      logic        hit;
   } vec_t;

   typedef struct packed {
      logic        v;
      logic        h;
      logic [11:0] c;
   } px_t;

   logic        clk;
   logic        rst_n;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        vsync;
   logic [9:0]  spr_x;
   logic [9:0]  spr_y;
   logic [2:0]  spr_frame;
   logic        tb_flip;
   logic        rom_en;
   logic [13:0] rom_addr;
   logic [11:0] rom_data;
   logic        px_valid;
   logic        px_hit;
   logic [11:0] px_color;

   int          n_checks;
   int          n_err;
   px_t         sb[$];
   string       tq[$];
   logic        pend;
   logic        pend_en;
   logic [13:0] pend_addr;
   logic [13:0] last_addr;
   string       pend_tag;
   vec_t        tbl[$];

   sprite_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_pix_valid (pix_valid),
      .i_pix_x     (pix_x),
      .i_pix_y     (pix_y),
      .i_vsync     (vsync),
      .i_spr_x     (spr_x),
      .i_spr_y     (spr_y),
      .i_spr_frame (spr_frame),
`ifdef SPRITE_HFLIP_EN
      .i_spr_flip  (tb_flip),
`endif
      .o_rom_en    (rom_en),
      .o_rom_addr  (rom_addr),
      .i_rom_data  (rom_data),
      .o_px_valid  (px_valid),
      .o_px_hit    (px_hit),
      .o_px_color  (px_color)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM content; address 4198 holds the colour key
   function automatic logic [11:0] rom_fn(input logic [13:0] a);
      if (a == 14'd4198) return 12'hF0F;
      return 12'(32'(a) * 7 + 3);
   endfunction

   // Synchronous ROM: data valid one cycle after rom_en is seen
   always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

   function automatic vec_t mk(input int pv, input int x, input int y, input int vs,
                               input int sx, input int sy, input int fr,
                               input int en, input int addr, input int hit);
      vec_t v;
      v.pv = 1'(pv);   v.x = 10'(x);   v.y = 10'(y);   v.vs = 1'(vs);
      v.sx = 10'(sx);  v.sy = 10'(sy); v.fr = 3'(fr);
      v.en = 1'(en);   v.addr = 14'(addr); v.hit = 1'(hit);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One cycle: check last cycle's ROM request and the matured output, then drive
   task automatic apply(input vec_t v, input string tag);
      px_t   e;
      string et;
      @(negedge clk);
      if (pend) begin
         chk({pend_tag, " rom_en"}, 32'(rom_en), 32'(pend_en));
         chk({pend_tag, " rom_addr"}, 32'(rom_addr), 32'(pend_addr));
      end
      if (sb.size() >= 3) begin
         e  = sb.pop_front();
         et = tq.pop_front();
         chk({et, " px_valid"}, 32'(px_valid), 32'(e.v));
         chk({et, " px_hit"}, 32'(px_hit), 32'(e.h));
         chk({et, " px_color"}, 32'(px_color), 32'(e.c));
      end
      pix_valid = v.pv; pix_x = v.x; pix_y = v.y; vsync = v.vs;
      spr_x = v.sx; spr_y = v.sy; spr_frame = v.fr;
      pend    = 1'b1;
      pend_en = v.en;
      if (v.en) last_addr = v.addr;
      pend_addr = last_addr;
      pend_tag  = tag;
      e.v = v.pv;
      e.h = v.hit;
      e.c = v.hit ? rom_fn(v.addr) : 12'h000;
      sb.push_back(e);
      tq.push_back(tag);
   endtask

   // Reset asserted between edges; outputs must clear immediately
   task automatic do_reset(input string tag);
      pix_valid = 1'b0;
      vsync     = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, " rst rom_en"}, 32'(rom_en), 32'd0);
      chk({tag, " rst rom_addr"}, 32'(rom_addr), 32'd0);
      chk({tag, " rst px_valid"}, 32'(px_valid), 32'd0);
      chk({tag, " rst px_hit"}, 32'(px_hit), 32'd0);
      chk({tag, " rst px_color"}, 32'(px_color), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      tq.delete();
      repeat (3) begin
         sb.push_back('0);
         tq.push_back({tag, " post-release"});
      end
      pend      = 1'b1;
      pend_en   = 1'b0;
      pend_addr = 14'd0;
      last_addr = 14'd0;
      pend_tag  = {tag, " release"};
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_err = 0; pend = 1'b0; last_addr = '0;
      rst_n = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; vsync = 1'b0;
      spr_x = '0; spr_y = '0; spr_frame = '0; tb_flip = 1'b0; rom_data = '0;

      //             pv  x    y    vs sx    sy  fr en addr   hit
      // WAIT_FRAME: nothing fetched even where a 0,0 sprite would cover the pixel
      tbl.push_back(mk(1, 100, 100, 0, 0,    0,  0, 0, 0,     0));
      tbl.push_back(mk(1, 5,   5,   0, 0,    0,  0, 0, 0,     0));
      tbl.push_back(mk(0, 5,   5,   0, 0,    0,  0, 0, 0,     0));
      tbl.push_back(mk(1, 5,   5,   0, 0,    0,  0, 0, 0,     0));
      // First vsync rise coinciding with a pixel: still waiting for that pixel
      tbl.push_back(mk(1, 105, 53,  1, 100,  50, 2, 0, 0,     0));
      tbl.push_back(mk(1, 105, 53,  1, 100,  50, 2, 1, 4197,  1));
      tbl.push_back(mk(1, 106, 53,  1, 100,  50, 2, 1, 4198,  0));
      tbl.push_back(mk(1, 132, 53,  1, 100,  50, 2, 0, 0,     0));
      tbl.push_back(mk(1, 131, 53,  1, 100,  50, 2, 1, 4223,  1));
      tbl.push_back(mk(1, 99,  53,  1, 100,  50, 2, 0, 0,     0));
      tbl.push_back(mk(1, 100, 50,  1, 100,  50, 2, 1, 4096,  1));
      tbl.push_back(mk(1, 100, 113, 1, 100,  50, 2, 1, 6112,  1));
      tbl.push_back(mk(1, 100, 114, 1, 100,  50, 2, 0, 0,     0));
      tbl.push_back(mk(0, 105, 53,  1, 100,  50, 2, 0, 0,     0));
      // Mid-frame move to 200 ignored until the next rise
      tbl.push_back(mk(1, 105, 53,  1, 200,  50, 2, 1, 4197,  1));
      tbl.push_back(mk(1, 205, 53,  1, 200,  50, 2, 0, 0,     0));
      tbl.push_back(mk(1, 205, 53,  0, 200,  50, 2, 0, 0,     0));
      tbl.push_back(mk(1, 205, 53,  1, 200,  50, 2, 0, 0,     0));
      tbl.push_back(mk(1, 205, 53,  1, 200,  50, 2, 1, 4197,  1));
      tbl.push_back(mk(1, 105, 53,  1, 200,  50, 2, 0, 0,     0));
      // Right screen edge, frame 7, no wrap
      tbl.push_back(mk(0, 0,   0,   0, 1010, 0,  7, 0, 0,     0));
      tbl.push_back(mk(0, 0,   0,   1, 1010, 0,  7, 0, 0,     0));
      tbl.push_back(mk(1, 1023,0,   1, 1010, 0,  7, 1, 14349, 1));
      tbl.push_back(mk(1, 5,   0,   1, 1010, 0,  7, 0, 0,     0));
      tbl.push_back(mk(1, 1023,5,   1, 1010, 0,  7, 1, 14509, 1));
      tbl.push_back(mk(1, 1009,0,   1, 1010, 0,  7, 0, 0,     0));

      do_reset("init");
      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef SPRITE_HFLIP_EN
      // Mirrored sprite: dx=0 reads column 31, dx=31 reads column 0
      tb_flip = 1'b1;
      apply(mk(0, 0,   0,  0, 100, 50, 2, 0, 0,    0), "flip0");
      apply(mk(0, 0,   0,  1, 100, 50, 2, 0, 0,    0), "flip1");
      apply(mk(1, 100, 53, 1, 100, 50, 2, 1, 4223, 1), "flip2");
      apply(mk(1, 131, 53, 1, 100, 50, 2, 1, 4192, 1), "flip3");
      tb_flip = 1'b0;
`endif

      // Fill the pipeline with three hits, then reset mid-flight
      apply(mk(0, 0,    0, 0, 1010, 0, 7, 0, 0,     0), "pre0");
      apply(mk(0, 0,    0, 1, 1010, 0, 7, 0, 0,     0), "pre1");
      apply(mk(1, 1023, 0, 1, 1010, 0, 7, 1, 14349, 1), "pre2");
      apply(mk(1, 1023, 5, 1, 1010, 0, 7, 1, 14509, 1), "pre3");
      apply(mk(1, 1023, 0, 1, 1010, 0, 7, 1, 14349, 1), "pre4");
      do_reset("mid");
      // Back in WAIT_FRAME with placement cleared to 0,0
      apply(mk(1, 5, 5, 0, 0, 0, 0, 0, 0,   0), "post0");
      apply(mk(1, 5, 5, 0, 0, 0, 0, 0, 0,   0), "post1");
      apply(mk(1, 5, 5, 1, 0, 0, 0, 0, 0,   0), "post2");
      apply(mk(1, 5, 5, 1, 0, 0, 0, 1, 165, 1), "post3");
      repeat (4) apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
